// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : Shared 640x480@60 timing constants, pixel/sync types and bar colours
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_PIPE_LAT  = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic disp;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, disp: 1'b0};
    localparam rgb_t  RGB_BLACK = '0;

    // Bars in order white, yellow, cyan, green, magenta, red, blue, black;
    // each primary is simply one inverted bit of the 80-px bar index.
    function automatic rgb_t bar_color(input logic [9:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 10'(i * 80)) idx = 3'(i);
        end
        return '{r: {8{~idx[1]}}, g: {8{~idx[2]}}, b: {8{~idx[0]}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_delay_line.sv
// ============================================================================
// Module  : sync_delay_line
// Brief   : Enable-gated shift register of any type, sync reset to RST_VAL
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_delay_line #(
    parameter int  DEPTH   = 2,
    parameter type T       = logic,
    parameter T    RST_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  T     i_d,
    output T     o_q
);

    T r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Scan counters, 640x480 sync timing, pipeline-aligned VGA pins.
//           Build option VGA_TEST_PATTERN_EN adds test_mode (built-in bars).
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int PIPE_LAT  = VGA_PIPE_LAT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pix_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    input  logic [7:0] map_R,
    input  logic [7:0] map_G,
    input  logic [7:0] map_B,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam logic [9:0] c_h_last     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_frame_start;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    rgb_t       r_rgb;

    sync_t      w_raw;
    sync_t      w_dly;
    rgb_t       w_src;
    rgb_t       w_map;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (pix_en) begin
                if (r_x == c_h_last) begin
                    r_x <= '0;
                    if (r_y == c_v_last) begin
                        r_y           <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_y <= r_y + 10'd1;
                    end
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end
        end
    end

    always_comb begin
        w_raw      = SYNC_IDLE;
        w_raw.hs   = !((r_x >= c_hs_start) && (r_x < c_hs_end));
        w_raw.vs   = !((r_y >= c_vs_start) && (r_y < c_vs_end));
        w_raw.disp = (r_x < c_h_vis) && (r_y < c_v_vis);
    end

    sync_delay_line #(
        .DEPTH   (PIPE_LAT),
        .T       (sync_t),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk  (Clk),
        .rst  (Reset),
        .i_en (pix_en),
        .i_d  (w_raw),
        .o_q  (w_dly)
    );

    assign w_map = '{r: map_R, g: map_G, b: map_B};

`ifdef VGA_TEST_PATTERN_EN
    rgb_t w_pat_dly;

    // Bar colour is generated at counter time so it lines up with the sync path.
    sync_delay_line #(
        .DEPTH   (PIPE_LAT),
        .T       (rgb_t),
        .RST_VAL (RGB_BLACK)
    ) u_pat_dly (
        .clk  (Clk),
        .rst  (Reset),
        .i_en (pix_en),
        .i_d  (bar_color(r_x)),
        .o_q  (w_pat_dly)
    );

    assign w_src = test_mode ? w_pat_dly : w_map;
`else
    assign w_src = w_map;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= RGB_BLACK;
        end else if (pix_en) begin
            r_hs      <= w_dly.hs;
            r_vs      <= w_dly.vs;
            r_blank_n <= w_dly.disp;
            r_rgb     <= w_dly.disp ? w_src : RGB_BLACK;
        end
    end

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign frame_start = r_frame_start;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_rgb.r;
    assign VGA_G       = r_rgb.g;
    assign VGA_B       = r_rgb.b;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Directed bench: default 640x480 instance plus a tiny-timing instance
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       pix_en = 1'b0;
    logic [7:0] map_R = '0, map_G = '0, map_B = '0;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode = 1'b0;
`endif

    logic [9:0] DrawX, DrawY, s_DrawX, s_DrawY;
    logic       frame_start, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic       s_frame_start, s_HS, s_VS, s_BLANK_N, s_SYNC_N;
    logic [7:0] VGA_R, VGA_G, VGA_B, s_R, s_G, s_B;

    int n_checks = 0;
    int n_fail   = 0;
    int T        = 0;     // pix_en ticks since the last reset
    logic fs_def, fs_small;

    always #5 Clk = ~Clk;

    vga_timing_gen u_dut (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .map_R(map_R), .map_G(map_G), .map_B(map_B),
        .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    // 24 x 12 raster (288 ticks/frame) so full-frame behaviour fits the run.
    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(2)
    ) u_small (
        .Clk(Clk), .Reset(Reset), .pix_en(pix_en),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .map_R(map_R), .map_G(map_G), .map_B(map_B),
        .DrawX(s_DrawX), .DrawY(s_DrawY), .frame_start(s_frame_start),
        .VGA_HS(s_HS), .VGA_VS(s_VS), .VGA_BLANK_N(s_BLANK_N),
        .VGA_SYNC_N(s_SYNC_N), .VGA_R(s_R), .VGA_G(s_G), .VGA_B(s_B)
    );

    function automatic logic [23:0] ramp(input int x);
        logic [9:0] xv;
        xv = 10'(x);
        return {xv[7:0], ~xv[7:0], xv[9:2]};
    endfunction

    // Expected {HS, VS, BLANK_N, R, G, B} for the default raster after t ticks.
    function automatic logic [26:0] model(input int t);
        int c, x, y;
        logic hs, vs, bl;
        if (t < 3) return {1'b1, 1'b1, 1'b0, 24'h0};
        c  = t - 3;
        x  = c % 800;
        y  = (c / 800) % 525;
        hs = !(x >= 656 && x < 752);
        vs = !(y >= 490 && y < 492);
        bl = (x < 640) && (y < 480);
        return {hs, vs, bl, bl ? ramp(x) : 24'h0};
    endfunction

    // One pixel tick: mapper answers for the coordinate shown two ticks earlier.
    task automatic tick();
        int c;
        c = T - 2;
        {map_R, map_G, map_B} = (c >= 0) ? ramp(c % 800) : 24'h0;
        pix_en = 1'b1;
        @(posedge Clk); #1;
        pix_en   = 1'b0;
        fs_def   = frame_start;
        fs_small = s_frame_start;
        @(posedge Clk); #1;
        T++;
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        pix_en = 1'b1;
        @(posedge Clk); #1;
        Reset  = 1'b0;
        pix_en = 1'b0;
        T      = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (DrawX !== 10'd0) begin n_fail++; $display("FAIL reset_drawx got %0d want 0", DrawX); end
        n_checks++; if (DrawY !== 10'd0) begin n_fail++; $display("FAIL reset_drawy got %0d want 0", DrawY); end
        n_checks++; if (VGA_HS !== 1'b1) begin n_fail++; $display("FAIL reset_hs got %b want 1", VGA_HS); end
        n_checks++; if (VGA_VS !== 1'b1) begin n_fail++; $display("FAIL reset_vs got %b want 1", VGA_VS); end
        n_checks++; if (VGA_BLANK_N !== 1'b0) begin n_fail++; $display("FAIL reset_blank got %b want 0", VGA_BLANK_N); end
        n_checks++; if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 000000", {VGA_R, VGA_G, VGA_B}); end
        n_checks++; if (VGA_SYNC_N !== 1'b0) begin n_fail++; $display("FAIL reset_sync_n got %b want 0", VGA_SYNC_N); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int hs_first = -1;
        for (int i = 0; i < 810; i++) begin
            tick();
            n_checks++;
            if (DrawX !== 10'(T % 800) || DrawY !== 10'(T / 800)) begin
                n_fail++; $display("FAIL line_xy t=%0d got (%0d,%0d) want (%0d,%0d)", T, DrawX, DrawY, T % 800, T / 800);
            end
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== model(T)) begin
                n_fail++; $display("FAIL line_pins t=%0d got %h want %h", T, {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, model(T));
            end
            if (VGA_HS === 1'b0 && T <= 800) begin
                hs_low++;
                if (hs_first < 0) hs_first = T;
            end
        end
        n_checks++; if (hs_low != 96) begin n_fail++; $display("FAIL hs_low_count got %0d want 96", hs_low); end
        n_checks++; if (hs_first != 659) begin n_fail++; $display("FAIL hs_first_tick got %0d want 659", hs_first); end
    endtask

    task automatic test_freeze();
        map_R = 8'h5a; map_G = 8'ha5; map_B = 8'h3c;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (frame_start !== 1'b0 || DrawX !== 10'(T % 800) ||
                {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== model(T)) begin
                n_fail++; $display("FAIL freeze clk=%0d got x=%0d pins=%h want x=%0d pins=%h",
                                   i, DrawX, {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, T % 800, model(T));
            end
        end
        tick();
        n_checks++; if (DrawX !== 10'(T % 800)) begin n_fail++; $display("FAIL resume_x got %0d want %0d", DrawX, T % 800); end
        n_checks++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== model(T)) begin
            n_fail++; $display("FAIL resume_pins got %h want %h", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, model(T));
        end
    endtask

    task automatic test_reset_mid();
        while (T != 1100) tick();
        n_checks++; if (DrawX !== 10'd300 || DrawY !== 10'd1) begin n_fail++; $display("FAIL mid_pos got (%0d,%0d) want (300,1)", DrawX, DrawY); end
        do_reset();
        n_checks++;
        if ({DrawX, DrawY} !== 20'd0 || {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {3'b110, 24'h0}) begin
            n_fail++; $display("FAIL mid_reset got x=%0d y=%0d pins=%h want 0 0 %h",
                               DrawX, DrawY, {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, {3'b110, 24'h0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== model(T)) begin
                n_fail++; $display("FAIL post_reset_pins t=%0d got %h want %h", T, {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, model(T));
            end
        end
    endtask

    task automatic test_frame();
        int fs_cnt = 0, fs_t = -1, def_fs = 0, vs_low = 0, vs_first = -1;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (fs_def) def_fs++;
            if (fs_small) begin
                fs_cnt++;
                fs_t = T;
                n_checks++;
                if (s_DrawX !== 10'd0 || s_DrawY !== 10'd0) begin
                    n_fail++; $display("FAIL frame_start_pos got (%0d,%0d) want (0,0)", s_DrawX, s_DrawY);
                end
            end
            if (s_VS === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = T;
            end
        end
        n_checks++; if (fs_cnt != 1) begin n_fail++; $display("FAIL frame_start_count got %0d want 1", fs_cnt); end
        n_checks++; if (fs_t != 288) begin n_fail++; $display("FAIL frame_start_tick got %0d want 288", fs_t); end
        n_checks++; if (def_fs != 0) begin n_fail++; $display("FAIL default_frame_start got %0d want 0", def_fs); end
        n_checks++; if (vs_low != 48) begin n_fail++; $display("FAIL vs_low_ticks got %0d want 48", vs_low); end
        n_checks++; if (vs_first != 219) begin n_fail++; $display("FAIL vs_first_tick got %0d want 219", vs_first); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        do_reset();
        test_mode = 1'b1;
        while (T != 103) tick();
        n_checks++; if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'hffff00}) begin
            n_fail++; $display("FAIL pattern_x100 got %h want 1ffff00", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}); end
        while (T != 603) tick();
        n_checks++; if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h000000}) begin
            n_fail++; $display("FAIL pattern_x600 got %h want 1000000", {VGA_BLANK_N, VGA_R, VGA_G, VGA_B}); end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        test_reset();
        test_line();
        test_freeze();
        test_reset_mid();
        test_frame();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
